// File: rtl/mem_clear_seq.sv
// mem_clear_seq: ce-paced memory clear/fill sequencer (IDLE -> SETUP -> WRITE ... -> DONE).
// Optional macro MEM_CLEAR_PATTERN_EN enables the incrementing data pattern (fill_data + offset).
module mem_clear_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pattern_mode,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W:0] OFFSET_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W:0]   offset_reg, offset_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [DATA_W-1:0] fill_reg, fill_next;
  logic [ADDR_W:0]   offset_inc;
`ifdef MEM_CLEAR_PATTERN_EN
  logic              pattern_reg, pattern_next;
`endif

  assign offset_inc = offset_reg + OFFSET_ONE;

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    count_next  = count_reg;
    base_next   = base_reg;
    fill_next   = fill_reg;
`ifdef MEM_CLEAR_PATTERN_EN
    pattern_next = pattern_reg;
`endif
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            base_next   = base_addr;
            fill_next   = fill_data;
            offset_next = '0;
            // length of zero means the whole address space, hence the extra count bit
            count_next  = (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, length};
`ifdef MEM_CLEAR_PATTERN_EN
            pattern_next = pattern_mode;
`endif
            state_next  = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ce) state_next = ST_WRITE;
        end
        ST_WRITE: begin
          if (ce && mem_ready) begin
            offset_next = offset_inc;
            state_next  = (offset_inc == count_reg) ? ST_DONE : ST_SETUP;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      offset_reg <= '0;
      count_reg  <= '0;
      base_reg   <= '0;
      fill_reg   <= '0;
`ifdef MEM_CLEAR_PATTERN_EN
      pattern_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      count_reg  <= count_next;
      base_reg   <= base_next;
      fill_reg   <= fill_next;
`ifdef MEM_CLEAR_PATTERN_EN
      pattern_reg <= pattern_next;
`endif
    end
  end

  // Outputs derive from registers only, so they hold still through a stall
  assign mem_addr = base_reg + offset_reg[ADDR_W-1:0];
  assign mem_we   = (state_reg == ST_WRITE);
  assign busy     = (state_reg == ST_SETUP) || (state_reg == ST_WRITE);
  assign done     = (state_reg == ST_DONE);

`ifdef MEM_CLEAR_PATTERN_EN
  logic [DATA_W-1:0] offset_ext;
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_offset_ext
      if (gi < ADDR_W + 1) begin : g_bit
        assign offset_ext[gi] = offset_reg[gi];
      end else begin : g_zero
        assign offset_ext[gi] = 1'b0;
      end
    end
  endgenerate
  assign mem_din = pattern_reg ? (fill_reg + offset_ext) : fill_reg;
`else
  logic pattern_unused;
  assign pattern_unused = pattern_mode;
  assign mem_din = fill_reg;
`endif

endmodule

// File: tb/tb_mem_clear_seq.sv
// tb_mem_clear_seq: table-driven runs on a 16-bit-address instance plus hand sequences for
// stall, abort, reset and ignored starts; a 4-bit-address instance covers length=0.
module tb_mem_clear_seq;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset, ce, start, abort, pattern_mode, mem_ready;
  logic [15:0] base_addr, length, mem_addr;
  logic [7:0]  fill_data, mem_din;
  logic        mem_we, busy, done;

  logic        ce_b, start_b;
  logic [3:0]  base_b, len_b, addr_b;
  logic [7:0]  din_b;
  logic        we_b, busy_b, done_b;

  mem_clear_seq #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .fill_data(fill_data),
    .pattern_mode(pattern_mode), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .busy(busy), .done(done)
  );

  mem_clear_seq #(.ADDR_W(4), .DATA_W(8)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ce(ce_b), .start(start_b), .abort(abort),
    .base_addr(base_b), .length(len_b), .fill_data(fill_data),
    .pattern_mode(pattern_mode), .mem_ready(mem_ready),
    .mem_addr(addr_b), .mem_din(din_b), .mem_we(we_b), .busy(busy_b), .done(done_b)
  );

  // Write/pulse capture on the falling edge: a write is committed at the next rising edge
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [3:0]  wrb_addr_q[$];
  logic [7:0]  wrb_data_q[$];
  int done_cnt = 0, done_b_cnt = 0, busy_b_cnt = 0;

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (mem_we && ce && mem_ready && !abort) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_din);
      end
      if (we_b && ce_b && mem_ready && !abort) begin
        wrb_addr_q.push_back(addr_b);
        wrb_data_q.push_back(din_b);
      end
      if (done)   done_cnt++;
      if (done_b) done_b_cnt++;
      if (busy_b) busy_b_cnt++;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_a(input logic [15:0] b, input logic [15:0] l, input logic [7:0] f,
                         input logic p);
    base_addr = b; length = l; fill_data = f; pattern_mode = p; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done_a(input int gap, input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      ce = ((c % gap) == 0);
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    ce = 1'b0;
  endtask

  function automatic logic [7:0] exp_data(input logic [7:0] f, input logic p, input int i);
`ifdef MEM_CLEAR_PATTERN_EN
    return p ? (f + 8'(i)) : f;
`else
    return f;
`endif
  endfunction

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [7:0]  fill;
    logic        pat;
    int          gap;
    int          exp_n;
    logic [15:0] exp_last_addr;
    logic [7:0]  exp_last_pat;
    logic [7:0]  exp_last_const;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w0, d0, n, b0;
    bit seen;
    logic [7:0] last_exp;

    vecs[0] = '{16'hFFFE, 16'd4, 8'h00, 1'b0, 4, 4, 16'h0001, 8'h00, 8'h00};
    vecs[1] = '{16'h0100, 16'd3, 8'hFE, 1'b1, 1, 3, 16'h0102, 8'h00, 8'hFE};
    vecs[2] = '{16'h1234, 16'd1, 8'hA5, 1'b0, 2, 1, 16'h1234, 8'hA5, 8'hA5};
    vecs[3] = '{16'h00F0, 16'd5, 8'h10, 1'b1, 3, 5, 16'h00F4, 8'h14, 8'h10};
    vecs[4] = '{16'hFFFF, 16'd2, 8'h80, 1'b1, 1, 2, 16'h0000, 8'h81, 8'h80};

    reset = 1'b1; ce = 1'b0; start = 1'b0; abort = 1'b0; pattern_mode = 1'b0;
    mem_ready = 1'b1; base_addr = '0; length = '0; fill_data = '0;
    ce_b = 1'b0; start_b = 1'b0; base_b = '0; len_b = '0;
    step(); step();
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_din", 32'(mem_din), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_b_busy", 32'(busy_b), 32'h0);
    reset = 1'b0;
    step();

    // Table-driven runs
    for (int v = 0; v < 5; v++) begin
      w0 = wr_addr_q.size();
      d0 = done_cnt;
      start_a(vecs[v].base, vecs[v].len, vecs[v].fill, vecs[v].pat);
      check($sformatf("v%0d_setup_busy", v), 32'(busy), 32'h1);
      check($sformatf("v%0d_setup_we", v), 32'(mem_we), 32'h0);
      check($sformatf("v%0d_setup_addr", v), 32'(mem_addr), 32'(vecs[v].base));
      wait_done_a(vecs[v].gap, 400, seen);
      check($sformatf("v%0d_done_seen", v), 32'(seen), 32'h1);
      step(); step();
      n = wr_addr_q.size() - w0;
      check($sformatf("v%0d_nwrites", v), 32'(n), 32'(vecs[v].exp_n));
      for (int i = 0; i < n && i < vecs[v].exp_n; i++) begin
        check($sformatf("v%0d_addr%0d", v, i), 32'(wr_addr_q[w0+i]), 32'(16'(vecs[v].base + 16'(i))));
        check($sformatf("v%0d_data%0d", v, i), 32'(wr_data_q[w0+i]),
              32'(exp_data(vecs[v].fill, vecs[v].pat, i)));
      end
`ifdef MEM_CLEAR_PATTERN_EN
      last_exp = vecs[v].pat ? vecs[v].exp_last_pat : vecs[v].exp_last_const;
`else
      last_exp = vecs[v].exp_last_const;
`endif
      if (n > 0) begin
        check($sformatf("v%0d_last_addr", v), 32'(wr_addr_q[w0+n-1]), 32'(vecs[v].exp_last_addr));
        check($sformatf("v%0d_last_data", v), 32'(wr_data_q[w0+n-1]), 32'(last_exp));
      end
      check($sformatf("v%0d_done_pulses", v), 32'(done_cnt - d0), 32'h1);
      check($sformatf("v%0d_idle_busy", v), 32'(busy), 32'h0);
      $display("vec %0d: base=0x%04h len=%0d fill=0x%02h pat=%0d writes=%0d",
               v, vecs[v].base, vecs[v].len, vecs[v].fill, vecs[v].pat, n);
    end

    // length=0 on the 4-bit instance: 16 writes, busy 32 cycles
    w0 = wrb_addr_q.size(); d0 = done_b_cnt; b0 = busy_b_cnt;
    fill_data = 8'h3C; pattern_mode = 1'b0; base_b = 4'h0; len_b = 4'h0; start_b = 1'b1;
    step();
    start_b = 1'b0; ce_b = 1'b1; seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done_b) begin seen = 1'b1; break; end
    end
    ce_b = 1'b0;
    step(); step();
    check("b_done_seen", 32'(seen), 32'h1);
    n = wrb_addr_q.size() - w0;
    check("b_nwrites", 32'(n), 32'd16);
    for (int i = 0; i < n && i < 16; i++) begin
      check($sformatf("b_addr%0d", i), 32'(wrb_addr_q[w0+i]), 32'(i));
      check($sformatf("b_data%0d", i), 32'(wrb_data_q[w0+i]), 32'h3C);
    end
    check("b_busy_cycles", 32'(busy_b_cnt - b0), 32'd32);
    check("b_done_pulses", 32'(done_b_cnt - d0), 32'h1);
    $display("len0 run: writes=%0d busy_cycles=%0d", n, busy_b_cnt - b0);

    // Stall on the second write for 10 ce pulses
    w0 = wr_addr_q.size();
    start_a(16'h0400, 16'd3, 8'h55, 1'b0);
    ce = 1'b1; seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if ((wr_addr_q.size() - w0) == 1 && mem_we) begin seen = 1'b1; break; end
      step();
    end
    check("stall_reach", 32'(seen), 32'h1);
    mem_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("stall%0d_we", k), 32'(mem_we), 32'h1);
      check($sformatf("stall%0d_addr", k), 32'(mem_addr), 32'h0401);
      check($sformatf("stall%0d_din", k), 32'(mem_din), 32'h55);
    end
    mem_ready = 1'b1;
    wait_done_a(1, 50, seen);
    check("stall_done_seen", 32'(seen), 32'h1);
    n = wr_addr_q.size() - w0;
    check("stall_nwrites", 32'(n), 32'd3);
    if (n == 3) begin
      check("stall_addr1", 32'(wr_addr_q[w0+1]), 32'h0401);
      check("stall_addr2", 32'(wr_addr_q[w0+2]), 32'h0402);
    end
    $display("stall run: writes=%0d", n);

    // Abort during the third WRITE of a length=8 run
    step();
    w0 = wr_addr_q.size(); d0 = done_cnt;
    start_a(16'h0500, 16'd8, 8'h11, 1'b0);
    ce = 1'b1; seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if ((wr_addr_q.size() - w0) == 2 && mem_we) begin seen = 1'b1; break; end
      step();
    end
    check("abort_reach", 32'(seen), 32'h1);
    ce = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_we", 32'(mem_we), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    ce = 1'b1;
    step(); step(); step(); step();
    ce = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'h0);
    check("abort_no_done", 32'(done_cnt - d0), 32'h0);
    check("abort_nwrites", 32'(wr_addr_q.size() - w0), 32'd2);
    w0 = wr_addr_q.size();
    start_a(16'h0500, 16'd2, 8'h11, 1'b0);
    check("restart_addr", 32'(mem_addr), 32'h0500);
    wait_done_a(1, 50, seen);
    check("restart_done_seen", 32'(seen), 32'h1);
    if (wr_addr_q.size() - w0 > 0) check("restart_first", 32'(wr_addr_q[w0]), 32'h0500);
    $display("abort run: restart writes=%0d", wr_addr_q.size() - w0);

    // Start while busy is ignored, then start during DONE is ignored
    step();
    w0 = wr_addr_q.size();
    start_a(16'h0200, 16'd2, 8'h22, 1'b0);
    ce = 1'b1;
    step();
    base_addr = 16'h0300; length = 16'd5; fill_data = 8'h99; start = 1'b1;
    step();
    start = 1'b0;
    wait_done_a(1, 50, seen);
    check("busy_start_done_seen", 32'(seen), 32'h1);
    check("busy_start_nwrites", 32'(wr_addr_q.size() - w0), 32'd2);
    if (wr_addr_q.size() - w0 == 2) begin
      check("busy_start_addr1", 32'(wr_addr_q[w0+1]), 32'h0201);
      check("busy_start_data1", 32'(wr_data_q[w0+1]), 32'h22);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_start_busy0", 32'(busy), 32'h0);
    step();
    check("done_start_busy1", 32'(busy), 32'h0);
    $display("ignored-start run: writes=%0d", wr_addr_q.size() - w0);

    // abort and start together in IDLE
    abort = 1'b1; start = 1'b1; base_addr = 16'h0700; length = 16'd1;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_start_busy0", 32'(busy), 32'h0);
    step();
    check("abort_start_busy1", 32'(busy), 32'h0);
    $display("abort+start: busy=%0d", busy);

    // Asynchronous reset mid-run
    start_a(16'h0600, 16'd8, 8'h77, 1'b0);
    ce = 1'b1;
    step(); step(); step();
    ce = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_addr", 32'(mem_addr), 32'h0);
    check("arst_din", 32'(mem_din), 32'h0);
    check("arst_we", 32'(mem_we), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    step();
    reset = 1'b0;
    ce = 1'b1;
    step(); step();
    ce = 1'b0;
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_we", 32'(mem_we), 32'h0);
    $display("reset run: busy=%0d we=%0d", busy, mem_we);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_clear_seq.md
MEM_CLEAR_SEQ -- requirements
Module: mem_clear_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word address width (range 4..24).
REQ-002 SHALL have parameter DATA_W, default 8, memory word data width (range 8..32).
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ce  input  1  pacing enable; one-cycle pulse, advances sequencer.
REQ-006 SHALL have port start  input  1  request a clear run; sampled every clk_sys cycle.
REQ-007 SHALL have port abort  input  1  terminate a run.
REQ-008 SHALL have port base_addr  input  ADDR_W  first word address.
REQ-009 SHALL have port length  input  ADDR_W  word count; 0 means 2^ADDR_W words.
REQ-010 SHALL have port fill_data  input  DATA_W  fill value.
REQ-011 SHALL have port pattern_mode  input  1  0 constant fill, 1 incrementing pattern.
REQ-012 SHALL have port mem_ready  input  1  memory accepts the current write.
REQ-013 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-014 SHALL have port mem_din  output  DATA_W  write data.
REQ-015 SHALL have port mem_we  output  1  write strobe.
REQ-016 SHALL have port busy  output  1  run in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, SETUP, WRITE, DONE; busy=1 in SETUP and WRITE only.
REQ-019 IDLE: start=1 and abort=0 latch base_addr, length, fill_data, pattern_mode, and load offset=0, then go to SETUP next cycle.
REQ-020 start SHALL be ignored while busy=1 or done=1; the latched values SHALL NOT change during a run.
REQ-021 SETUP: mem_addr=base+offset (mod 2^ADDR_W), mem_din set, mem_we=0; on ce go to WRITE.
REQ-022 WRITE: mem_we=1, mem_addr/mem_din held stable; on ce with mem_ready=1 go to SETUP with offset+1, or to DONE if offset+1 equals the latched count.
REQ-023 WRITE with ce=1 and mem_ready=0 SHALL stay in WRITE (stall) with all outputs unchanged; no write is skipped.
REQ-024 Each word therefore SHALL take a minimum of two ce pulses (one setup, one write).
REQ-025 mem_din SHALL be fill_data in constant mode and fill_data+offset[DATA_W-1:0] (mod 2^DATA_W) in pattern mode.
REQ-026 Address SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-027 The offset counter SHALL be ADDR_W+1 bits wide, so length=0 writes exactly 2^ADDR_W words.
REQ-028 DONE: done=1 and mem_we=0 for exactly one cycle, then IDLE; a start during DONE SHALL be ignored.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge, with mem_we=0, busy=0 and no done pulse.
REQ-030 If abort and start are both high in IDLE, abort SHALL win and no run SHALL start.
REQ-031 ce SHALL have no effect in IDLE or DONE.

Reset
REQ-032 Asserting reset at any time, including mid-run, SHALL immediately force IDLE, mem_addr=0, mem_din=0, mem_we=0, busy=0, done=0 and offset=0.
REQ-033 After reset deasserts, the first run SHALL require a fresh start.

Configuration
REQ-034 Macro MEM_CLEAR_PATTERN_EN defined: pattern_mode SHALL behave per REQ-025.
REQ-035 Macro MEM_CLEAR_PATTERN_EN undefined: pattern_mode SHALL be ignored, mem_din SHALL always equal latched fill_data, and no data adder SHALL be synthesised.

Verification
REQ-036 ADDR_W=16, base=0xFFFE, length=4, fill=0x00, ce every 4 cycles, mem_ready=1 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 with data 0x00, then one done pulse.
REQ-037 ADDR_W=4, length=0, ce every cycle -> exactly 16 writes to addresses 0..15, busy high for 32 cycles, then done.
REQ-038 Pattern mode (macro defined), fill=0xFE, length=3 -> data 0xFE, 0xFF, 0x00; rebuilt without the macro -> data 0xFE ×3.
REQ-039 mem_ready held low for 10 ce pulses during the second write -> mem_we, mem_addr and mem_din are stable throughout; the write completes after mem_ready rises; total write count equals length.
REQ-040 abort asserted during the third WRITE of a length=8 run -> mem_we=0 and busy=0 next cycle, no done pulse; a new start then begins again at base_addr.
REQ-041 reset pulsed mid-run -> all outputs read 0 asynchronously; a start pulse while busy or in DONE has no effect.
